// File: rtl/alu_cmd_issuer.sv
// Command issuer for the ALU execution units: accepts one operation, pulses the units,
// collects the flagged result (or a watchdog error) and returns it on a response handshake.
module alu_cmd_issuer #(
  parameter int OPER_WIDTH  = 8,
  parameter int OUT_WIDTH   = 16,
  parameter int TIMEOUT     = 4,
  parameter int OPCNT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [OPER_WIDTH-1:0]  req_a_i,
  input  logic [OPER_WIDTH-1:0]  req_b_i,
  input  logic [3:0]             req_func_i,
  output logic [OPER_WIDTH-1:0]  alu_a_o,
  output logic [OPER_WIDTH-1:0]  alu_b_o,
  output logic [3:0]             alu_func_o,
  output logic                   alu_en_o,
  input  logic [OUT_WIDTH-1:0]   alu_out_i,
  input  logic                   alu_flag_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [OUT_WIDTH-1:0]   rsp_data_o,
  output logic                   rsp_err_o,
  output logic [OPCNT_WIDTH-1:0] op_cnt_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                 state_q;
  logic                   req_ready_q;
  logic [OPER_WIDTH-1:0]  alu_a_q;
  logic [OPER_WIDTH-1:0]  alu_b_q;
  logic [3:0]             alu_func_q;
  logic                   alu_en_q;
  logic                   rsp_valid_q;
  logic [OUT_WIDTH-1:0]   rsp_data_q;
  logic                   rsp_err_q;
  logic [OPCNT_WIDTH-1:0] op_cnt_q;
  logic [WD_W-1:0]        wd_q;

  // NOTE: every state register uses non-blocking assignment so all of them update
  // together at the edge; reset is tested first so it overrides any handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      op_cnt_q    <= '0;
      wd_q        <= '0;
    end else begin
      alu_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            alu_a_q     <= req_a_i;
            alu_b_q     <= req_b_i;
            alu_func_q  <= req_func_i;
            alu_en_q    <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end else begin
            // Ready comes up one cycle after reset and stays up while idle.
            req_ready_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_flag_i) begin
            rsp_data_q  <= alu_out_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            op_cnt_q    <= op_cnt_q + 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_func_o  = alu_func_q;
  assign alu_en_o    = alu_en_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign op_cnt_o    = op_cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a two-stage ALU unit model (EN registered, then flag).
module tb_alu_cmd_issuer;

  localparam int OW = 8;
  localparam int RW = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [OW-1:0] req_a, req_b;
  logic [3:0]    req_func;
  logic [OW-1:0] alu_a, alu_b;
  logic [3:0]    alu_func;
  logic          alu_en;
  logic [RW-1:0] alu_out;
  logic          alu_flag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_data;
  logic          rsp_err;
  logic [CW-1:0] op_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Unit model: EN is registered inside the unit, the flag one stage later.
  logic          model_on;
  logic          stray;
  logic [RW-1:0] unit_result;
  logic          en_d = 1'b0;
  logic          flag_m = 1'b0;

  always @(posedge clk) begin
    en_d   <= alu_en;
    flag_m <= en_d & model_on;
  end

  assign alu_flag = flag_m | stray;
  assign alu_out  = flag_m ? unit_result : (stray ? 16'hFFFF : 16'h0000);

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .OPER_WIDTH (OW),
    .OUT_WIDTH  (RW),
    .TIMEOUT    (4),
    .OPCNT_WIDTH(CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .req_func_i (req_func),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_func_o (alu_func),
    .alu_en_o   (alu_en),
    .alu_out_i  (alu_out),
    .alu_flag_i (alu_flag),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err),
    .op_cnt_o   (op_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    req_a     = a;
    req_b     = b;
    req_func  = f;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    req_func    = '0;
    rsp_ready   = 1'b1;
    model_on    = 1'b1;
    stray       = 1'b0;
    unit_result = '0;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_en", alu_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_op_cnt", op_cnt, 0);
    check("rst_alu_a", alu_a, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1);

    // Shift op: handshake at edge k, RSP_VALID from k+3
    unit_result = 16'h004B;
    start_req(8'h96, 8'h01, 4'b1100);
    check("sh_en_k", alu_en, 1);
    check("sh_alu_a", alu_a, 8'h96);
    check("sh_alu_func", alu_func, 4'b1100);
    check("sh_ready_k", req_ready, 0);
    tick();
    check("sh_en_k1", alu_en, 0);
    check("sh_alu_a_held", alu_a, 8'h96);
    tick();
    check("sh_valid_k2", rsp_valid, 0);
    tick();
    check("sh_valid_k3", rsp_valid, 1);
    check("sh_data", rsp_data, 16'h004B);
    check("sh_err", rsp_err, 0);
    tick();
    check("sh_valid_done", rsp_valid, 0);
    check("sh_op_cnt", op_cnt, 1);
    check("sh_ready_back", req_ready, 1);

    // Stray flag in IDLE
    stray = 1'b1;
    tick();
    stray = 1'b0;
    check("stray_idle_ready", req_ready, 1);
    check("stray_idle_valid", rsp_valid, 0);
    check("stray_idle_en", alu_en, 0);

    // Timeout with consumer stalled
    model_on  = 1'b0;
    rsp_ready = 1'b0;
    start_req(8'h11, 8'h22, 4'b0000);
    tick();
    for (int i = 0; i < 3; i++) tick();
    check("to_valid_early", rsp_valid, 0);
    tick();
    check("to_valid", rsp_valid, 1);
    check("to_data", rsp_data, 0);
    check("to_err", rsp_err, 1);

    // Backpressure for 5 cycles, stray flag mid-way
    for (int i = 0; i < 5; i++) begin
      stray = (i == 2);
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 0);
      check("bp_err", rsp_err, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_alu_en", alu_en, 0);
    end
    stray     = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_release_ready", req_ready, 1);
    check("bp_release_valid", rsp_valid, 0);
    check("to_op_cnt", op_cnt, 2);

    // Reset during WAIT; the unit's flag arrives after reset and must be ignored
    model_on    = 1'b1;
    unit_result = 16'h1234;
    start_req(8'h33, 8'h44, 4'b0101);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_alu_a", alu_a, 0);
    check("rw_alu_func", alu_func, 0);
    check("rw_valid", rsp_valid, 0);
    check("rw_op_cnt", op_cnt, 0);
    check("rw_req_ready", req_ready, 0);
    tick();
    check("rw_ready_next", req_ready, 1);
    check("rw_late_flag_valid", rsp_valid, 0);
    tick();
    check("rw_still_idle_valid", rsp_valid, 0);
    check("rw_still_idle_data", rsp_data, 0);

    // Five back-to-back ops: counter wraps at 2 bits
    for (int n = 0; n < 5; n++) begin
      logic [CW-1:0] exp_cnt;
      logic [RW-1:0] exp_data;
      bit            seen;
      exp_cnt     = CW'(n + 1);
      exp_data    = RW'((n + 1) * 16'h0111);
      unit_result = exp_data;
      start_req(8'(n), 8'(n + 7), 4'b0100);
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        if (rsp_valid) seen = 1'b1;
        else tick();
      end
      check("wr_rsp_seen", 32'(seen), 1);
      check("wr_data", rsp_data, exp_data);
      tick();
      check("wr_op_cnt", op_cnt, exp_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
